// File: rtl/npu_pkg.sv
// npu_pkg: shared scheduler state, tag type and data-width default for the NPU layer blocks
package npu_pkg;
   localparam int DATA_WIDTH_DEF = 8;
   localparam int IDXW = 8;
   typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, OUT} sched_state_t;
   typedef struct packed {
      logic v;
      logic [IDXW-1:0] idx;
   } pe_tag_t;
endpackage

// File: rtl/pe_tag_pipe.sv
// pe_tag_pipe: fixed-depth shift register that tracks which neuron each Perceptron result belongs to
module pe_tag_pipe #(
   parameter int DEPTH = 4,
   parameter int W = 9
) (
   input  logic         clk,
   input  logic         rst,
   input  logic [W-1:0] din,
   output logic [W-1:0] dout
);
   logic [DEPTH-1:0][W-1:0] pipe_q, pipe_d;
   // shift every cycle, new tag enters at stage 0
   always_comb begin
      pipe_d[0] = din;
      for (int i = 1; i < DEPTH; i++) pipe_d[i] = pipe_q[i-1];
   end
   // reset drops every in-flight tag
   always_ff @(posedge clk or posedge rst)
      if (rst) pipe_q <= '0;
      else pipe_q <= pipe_d;
   assign dout = pipe_q[DEPTH-1];
endmodule

// File: rtl/perceptron_layer_sched.sv
// perceptron_layer_sched: time-multiplexes one Perceptron over the M neurons of a dense layer
module perceptron_layer_sched import npu_pkg::*; #(
   parameter int N = 4,
   parameter int M = 4,
   parameter int DATA_WIDTH = DATA_WIDTH_DEF,
   parameter int PE_LAT = 3,
   localparam int ADDR_W = (M > 1) ? $clog2(M) : 1,
   localparam int CNT_W = $clog2(M + 1)
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    in_valid,
   output logic                    in_ready,
   input  logic [N*DATA_WIDTH-1:0] in_x,
   output logic                    wmem_rd_en,
   output logic [ADDR_W-1:0]       wmem_addr,
   input  logic [N*DATA_WIDTH-1:0] wmem_w,
   input  logic [DATA_WIDTH-1:0]   wmem_b,
   output logic [N*DATA_WIDTH-1:0] pe_x,
   output logic [N*DATA_WIDTH-1:0] pe_w,
   output logic [DATA_WIDTH-1:0]   pe_b,
   input  logic [DATA_WIDTH-1:0]   pe_y,
   output logic                    out_valid,
   input  logic                    out_ready,
   output logic [M*DATA_WIDTH-1:0] out_y,
   output logic                    busy
);
   sched_state_t state_q, state_d;
   logic [CNT_W-1:0] issue_q, issue_d, cap_q, cap_d;
   logic [N*DATA_WIDTH-1:0] x_q, x_d;
   logic [M*DATA_WIDTH-1:0] y_q, y_d;
   logic op_v_q, op_v_d;
   pe_tag_t tag_in, tag_out;

   pe_tag_pipe #(.DEPTH(1 + PE_LAT), .W($bits(pe_tag_t))) u_tag (
      .clk  (clk),
      .rst  (rst),
      .din  (tag_in),
      .dout (tag_out)
   );

   // next-state, counters, result capture and handshake outputs
   always_comb begin
      state_d = state_q;
      issue_d = issue_q;
      cap_d = cap_q;
      x_d = x_q;
      y_d = y_q;
      in_ready = state_q == IDLE;
      wmem_rd_en = state_q == ISSUE;
      out_valid = state_q == OUT;
      busy = state_q != IDLE;
      wmem_addr = ADDR_W'(issue_q);
      op_v_d = wmem_rd_en;
      tag_in = '{v: wmem_rd_en, idx: IDXW'(issue_q)};
      if (tag_out.v) begin
         for (int k = 0; k < M; k++)
            if (tag_out.idx == IDXW'(k)) y_d[k*DATA_WIDTH +: DATA_WIDTH] = pe_y;
         cap_d = cap_q + 1'b1;
      end
      case (state_q)
         IDLE: if (in_valid) begin
            x_d = in_x;
            cap_d = '0;
            issue_d = '0;
            state_d = ISSUE;
         end
         ISSUE: begin
            issue_d = issue_q + 1'b1;
            if (issue_q == CNT_W'(M - 1)) begin
               issue_d = '0;
               state_d = DRAIN;
            end
         end
         DRAIN: if (cap_d == CNT_W'(M)) state_d = OUT;
         OUT: if (out_ready) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // state, counters, input vector and result registers
   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         state_q <= IDLE;
         issue_q <= '0;
         cap_q <= '0;
         x_q <= '0;
         y_q <= '0;
         op_v_q <= 1'b0;
      end else begin
         state_q <= state_d;
         issue_q <= issue_d;
         cap_q <= cap_d;
         x_q <= x_d;
         y_q <= y_d;
         op_v_q <= op_v_d;
      end

   assign pe_x = op_v_q ? x_q : '0;
   assign pe_w = op_v_q ? wmem_w : '0;
   assign pe_b = op_v_q ? wmem_b : '0;
   assign out_y = y_q;
endmodule

// File: tb/tb_perceptron_layer_sched.sv
// tb_perceptron_layer_sched: scoreboard bench with Perceptron and weight ROM models for M=4 and M=1 builds
module tb_perceptron_layer_sched;
   logic clk = 1'b0, rst = 1'b1;
   logic in_valid = 1'b0, in_ready, wmem_rd_en, out_valid, out_ready = 1'b1, busy;
   logic [31:0] in_x = '0, wmem_w, pe_x, pe_w, out_y;
   logic [1:0] wmem_addr;
   logic [7:0] wmem_b, pe_b, pe_y;
   logic in_valid1 = 1'b0, in_ready1, rd1, out_valid1, busy1;
   logic [31:0] in_x1 = '0, w1, pe_x1, pe_w1;
   logic [0:0] addr1;
   logic [7:0] b1, pe_b1, pe_y1, out_y1;
   logic [31:0] rom_w [4];
   logic [7:0] rom_b [4];
   logic [31:0] rom1_w = 32'h02_FD_01_04;
   logic [7:0] rom1_b = 8'hFE;
   logic [7:0] pp [3];
   logic [7:0] pp1 [3];
   logic [31:0] sb_q [$];
   logic [1:0] rd_addr_q [$];
   int cyc = 0, rd_cnt = 0, n_chk = 0, n_pass = 0;

   perceptron_layer_sched #(.N(4), .M(4), .DATA_WIDTH(8), .PE_LAT(3)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_x(in_x),
      .wmem_rd_en(wmem_rd_en), .wmem_addr(wmem_addr), .wmem_w(wmem_w), .wmem_b(wmem_b),
      .pe_x(pe_x), .pe_w(pe_w), .pe_b(pe_b), .pe_y(pe_y),
      .out_valid(out_valid), .out_ready(out_ready), .out_y(out_y), .busy(busy)
   );

   perceptron_layer_sched #(.N(4), .M(1), .DATA_WIDTH(8), .PE_LAT(3)) dut1 (
      .clk(clk), .rst(rst), .in_valid(in_valid1), .in_ready(in_ready1), .in_x(in_x1),
      .wmem_rd_en(rd1), .wmem_addr(addr1), .wmem_w(w1), .wmem_b(b1),
      .pe_x(pe_x1), .pe_w(pe_w1), .pe_b(pe_b1), .pe_y(pe_y1),
      .out_valid(out_valid1), .out_ready(1'b1), .out_y(out_y1), .busy(busy1)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   function automatic logic [7:0] pe_f(logic [31:0] x, logic [31:0] w, logic [7:0] b);
      int s = $signed(b);
      for (int i = 0; i < 4; i++) s += $signed(x[i*8 +: 8]) * $signed(w[i*8 +: 8]);
      return s > 127 ? 8'h7F : s < -128 ? 8'h80 : 8'(s);
   endfunction

   function automatic logic [31:0] layer_exp(logic [31:0] x);
      logic [31:0] r;
      for (int k = 0; k < 4; k++) r[k*8 +: 8] = pe_f(x, rom_w[k], rom_b[k]);
      return r;
   endfunction

   always @(posedge clk) begin
      if (wmem_rd_en) begin
         wmem_w <= rom_w[wmem_addr];
         wmem_b <= rom_b[wmem_addr];
      end
      if (rd1) begin
         w1 <= rom1_w;
         b1 <= rom1_b;
      end
      pp[0] <= pe_f(pe_x, pe_w, pe_b);
      pp[1] <= pp[0];
      pp[2] <= pp[1];
      pp1[0] <= pe_f(pe_x1, pe_w1, pe_b1);
      pp1[1] <= pp1[0];
      pp1[2] <= pp1[1];
   end
   assign pe_y = pp[2];
   assign pe_y1 = pp1[2];

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h", tag, got, exp);
   endtask

   always @(negedge clk) if (!rst) begin
      if (in_valid && in_ready) sb_q.push_back(layer_exp(in_x));
      if (wmem_rd_en) begin
         rd_cnt++;
         rd_addr_q.push_back(wmem_addr);
      end
      if (out_valid && out_ready) begin
         if (sb_q.size() == 0) check("sb_unexpected_out", 32'd0, 32'd1);
         else check("sb_out_y", out_y, sb_q.pop_front());
      end
   end

   task automatic send(input logic [31:0] x, output int acc);
      @(posedge clk); #1 in_valid = 1'b1; in_x = x; acc = -1;
      for (int i = 0; i < 100 && acc < 0; i++) begin
         @(negedge clk);
         if (in_ready) acc = cyc;
      end
      if (acc < 0) check("accept_timeout", 32'd0, 32'd1);
      @(posedge clk); #1 in_valid = 1'b0;
   endtask

   task automatic wait_out(output int c);
      c = -1;
      for (int i = 0; i < 100 && c < 0; i++) begin
         @(negedge clk);
         if (out_valid) c = cyc;
      end
      if (c < 0) check("out_timeout", 32'd0, 32'd1);
   endtask

   task automatic wait_drain();
      for (int i = 0; i < 200 && sb_q.size() > 0; i++) @(negedge clk);
      check("sb_drained", sb_q.size(), 32'd0);
   endtask

   initial begin
      int a, c, acc [3];
      logic [31:0] ya;
      for (int k = 0; k < 4; k++) begin
         rom_w[k] = {4{8'(k + 1)}};
         rom_b[k] = 8'd0;
      end
      @(negedge clk);
      check("rst_in_ready", in_ready, 32'd1);
      check("rst_busy", busy, 32'd0);
      check("rst_out_valid", out_valid, 32'd0);
      check("rst_rd_en", wmem_rd_en, 32'd0);
      check("rst_addr", wmem_addr, 32'd0);
      check("rst_pe", pe_x | pe_w | 32'(pe_b), 32'd0);
      check("rst_out_y", out_y, 32'd0);
      @(posedge clk); #1 rst = 1'b0;
      rd_cnt = 0;
      rd_addr_q.delete();
      send(32'h04_03_02_01, a);
      wait_out(c);
      check("t1_latency", c - a, 32'd9);
      check("t1_out_y", out_y, {8'd40, 8'd30, 8'd20, 8'd10});
      check("t1_rd_pulses", rd_cnt, 32'd4);
      for (int i = 0; i < 4; i++) check("t1_rd_addr", rd_addr_q[i], 32'(i));
      wait_drain();
      rom_w[0] = 32'hFF_FF_FF_FF; rom_b[0] = 8'd6;
      rom_w[1] = 32'hFB_04_FD_02; rom_b[1] = 8'hF9;
      rom_w[2] = 32'h7F_7F_7F_7F; rom_b[2] = 8'd0;
      rom_w[3] = 32'h80_80_80_80; rom_b[3] = 8'd3;
      send(32'h01_01_01_01, a);
      wait_out(c);
      check("t2_slot0", out_y[7:0], 32'd2);
      check("t2_slot2_sat", out_y[23:16], 32'h7F);
      check("t2_slot3_sat", out_y[31:24], 32'h80);
      wait_drain();
      out_ready = 1'b0;
      ya = layer_exp(32'h05_FE_03_01);
      send(32'h05_FE_03_01, a);
      wait_out(c);
      @(posedge clk); #1 in_valid = 1'b1; in_x = 32'h02_02_FF_07;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         check("t3_hold_valid", out_valid, 32'd1);
         check("t3_hold_y", out_y, ya);
         check("t3_hold_in_ready", in_ready, 32'd0);
      end
      @(posedge clk); #1 out_ready = 1'b1;
      @(negedge clk);
      check("t3_release_valid", out_valid, 32'd1);
      @(negedge clk);
      check("t3_idle_in_ready", in_ready, 32'd1);
      @(posedge clk); #1 in_valid = 1'b0;
      wait_out(c);
      wait_drain();
      @(posedge clk); #1 in_valid = 1'b1;
      for (int v = 0; v < 3; v++) begin
         in_x = 32'h11_F3_05_02 + 32'(v * 32'h03_01_FE_01);
         acc[v] = -1;
         for (int i = 0; i < 100 && acc[v] < 0; i++) begin
            @(negedge clk);
            if (in_ready) acc[v] = cyc;
         end
         @(posedge clk); #1;
      end
      in_valid = 1'b0;
      wait_drain();
      check("t4_spacing01", acc[1] - acc[0], 32'd10);
      check("t4_spacing12", acc[2] - acc[1], 32'd10);
      send(32'h09_09_09_09, a);
      repeat (5) @(posedge clk);
      #1 rst = 1'b1;
      #1;
      check("t5_rst_out_valid", out_valid, 32'd0);
      check("t5_rst_busy", busy, 32'd0);
      check("t5_rst_rd_en", wmem_rd_en, 32'd0);
      check("t5_rst_pe", pe_x | pe_w | 32'(pe_b), 32'd0);
      check("t5_rst_out_y", out_y, 32'd0);
      check("t5_rst_in_ready", in_ready, 32'd1);
      sb_q.delete();
      @(posedge clk); #1 rst = 1'b0;
      repeat (8) @(negedge clk);
      check("t5_no_stale", out_y, 32'd0);
      check("t5_idle", busy, 32'd0);
      rom_b[1] = 8'd20;
      send(32'hFD_02_04_03, a);
      wait_out(c);
      wait_drain();
      rd_cnt = 0;
      @(posedge clk); #1 in_valid1 = 1'b1; in_x1 = 32'h03_01_FF_02;
      a = -1;
      for (int i = 0; i < 50 && a < 0; i++) begin
         @(negedge clk);
         if (in_ready1) a = cyc;
      end
      @(posedge clk); #1 in_valid1 = 1'b0;
      c = -1;
      a = a < 0 ? 0 : a;
      begin
         int r1 = 0;
         for (int i = 0; i < 50 && c < 0; i++) begin
            @(negedge clk);
            if (rd1) r1++;
            check("t6_addr", 32'(addr1), 32'd0);
            if (out_valid1) c = cyc;
         end
         check("t6_rd_pulses", r1, 32'd1);
      end
      check("t6_latency", c - a, 32'd6);
      check("t6_out_y", out_y1, 32'(pe_f(32'h03_01_FF_02, rom1_w, rom1_b)));
      @(negedge clk);
      check("t6_in_ready_after", in_ready1, 32'd1);
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
